// File: rtl/axi_lite_arb_pkg.sv
// Shared types for the AXI4-Lite round-robin arbiter: path state encodings
// and AXI response codes.
package axi_lite_arb_pkg;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_XFER = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } rd_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr,
// wrapping modulo NUM_REQ.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_valid
);

  int cand;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(ptr) + k) % NUM_REQ;
      if (!gnt_valid && req[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/axi_lite_rr_arbiter.sv
// N-to-1 AXI4-Lite arbiter; write (AW+W+B) and read (AR+R) paths each hold a
// grant for the whole transaction and rotate their own round-robin pointer.
module axi_lite_rr_arbiter
  import axi_lite_arb_pkg::*;
#(
  parameter  int NUM_MASTERS = 4,
  parameter  int ADDR_WIDTH  = 32,
  parameter  int DATA_WIDTH  = 32,
  localparam int IDX_W       = $clog2(NUM_MASTERS),
  localparam int STRB_W      = DATA_WIDTH / 8
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] s_awaddr,
  input  logic [NUM_MASTERS-1:0]          s_awvalid,
  output logic [NUM_MASTERS-1:0]          s_awready,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] s_wdata,
  input  logic [NUM_MASTERS*STRB_W-1:0]   s_wstrb,
  input  logic [NUM_MASTERS-1:0]          s_wvalid,
  output logic [NUM_MASTERS-1:0]          s_wready,
  output logic [NUM_MASTERS*2-1:0]        s_bresp,
  output logic [NUM_MASTERS-1:0]          s_bvalid,
  input  logic [NUM_MASTERS-1:0]          s_bready,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] s_araddr,
  input  logic [NUM_MASTERS-1:0]          s_arvalid,
  output logic [NUM_MASTERS-1:0]          s_arready,
  output logic [NUM_MASTERS*DATA_WIDTH-1:0] s_rdata,
  output logic [NUM_MASTERS*2-1:0]        s_rresp,
  output logic [NUM_MASTERS-1:0]          s_rvalid,
  input  logic [NUM_MASTERS-1:0]          s_rready,
  output logic [ADDR_WIDTH-1:0]           m_awaddr,
  output logic                            m_awvalid,
  input  logic                            m_awready,
  output logic [DATA_WIDTH-1:0]           m_wdata,
  output logic [STRB_W-1:0]               m_wstrb,
  output logic                            m_wvalid,
  input  logic                            m_wready,
  input  logic [1:0]                      m_bresp,
  input  logic                            m_bvalid,
  output logic                            m_bready,
  output logic [ADDR_WIDTH-1:0]           m_araddr,
  output logic                            m_arvalid,
  input  logic                            m_arready,
  input  logic [DATA_WIDTH-1:0]           m_rdata,
  input  logic [1:0]                      m_rresp,
  input  logic                            m_rvalid,
  output logic                            m_rready,
  output logic [IDX_W-1:0]                wr_grant_idx,
  output logic [IDX_W-1:0]                rd_grant_idx,
  output logic                            wr_busy,
  output logic                            rd_busy
);

  // Handshake rule on every channel: a beat transfers on a rising ACLK where
  // valid && ready; sources hold valid and payload stable until that edge.

  wr_state_t        wr_state_q, wr_state_d;
  rd_state_t        rd_state_q, rd_state_d;
  logic [IDX_W-1:0] wr_gnt_q, wr_gnt_d, rd_gnt_q, rd_gnt_d;
  logic [IDX_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic             aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic [IDX_W-1:0] wr_arb_idx, rd_arb_idx;
  logic             wr_arb_valid, rd_arb_valid;

  function automatic logic [IDX_W-1:0] ptr_after(input logic [IDX_W-1:0] g);
    if (g == IDX_W'(NUM_MASTERS - 1)) return '0;
    return g + IDX_W'(1);
  endfunction

  rr_arbiter #(.NUM_REQ(NUM_MASTERS)) u_wr_arb (
    .req(s_awvalid), .ptr(wr_ptr_q), .gnt_idx(wr_arb_idx), .gnt_valid(wr_arb_valid)
  );

  rr_arbiter #(.NUM_REQ(NUM_MASTERS)) u_rd_arb (
    .req(s_arvalid), .ptr(rd_ptr_q), .gnt_idx(rd_arb_idx), .gnt_valid(rd_arb_valid)
  );

  // Payloads follow the registered grant; only valids are qualified.
  assign m_awaddr = s_awaddr[int'(wr_gnt_q)*ADDR_WIDTH +: ADDR_WIDTH];
  assign m_wdata  = s_wdata[int'(wr_gnt_q)*DATA_WIDTH +: DATA_WIDTH];
  assign m_wstrb  = s_wstrb[int'(wr_gnt_q)*STRB_W +: STRB_W];
  assign m_araddr = s_araddr[int'(rd_gnt_q)*ADDR_WIDTH +: ADDR_WIDTH];
  assign s_bresp  = {NUM_MASTERS{m_bresp}};
  assign s_rresp  = {NUM_MASTERS{m_rresp}};
  assign s_rdata  = {NUM_MASTERS{m_rdata}};

  assign wr_grant_idx = wr_gnt_q;
  assign rd_grant_idx = rd_gnt_q;
  assign wr_busy      = (wr_state_q != W_IDLE);
  assign rd_busy      = (rd_state_q != R_IDLE);

  always_comb begin
    wr_state_d = wr_state_q;
    wr_gnt_d   = wr_gnt_q;
    wr_ptr_d   = wr_ptr_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    s_awready  = '0;
    s_wready   = '0;
    s_bvalid   = '0;
    m_awvalid  = 1'b0;
    m_wvalid   = 1'b0;
    m_bready   = 1'b0;
    case (wr_state_q)
      W_IDLE: begin
        if (wr_arb_valid) begin
          wr_gnt_d   = wr_arb_idx;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          wr_state_d = W_XFER;
        end
      end
      W_XFER: begin
        // AW and W complete independently, in either order.
        m_awvalid           = s_awvalid[wr_gnt_q] && !aw_done_q;
        m_wvalid            = s_wvalid[wr_gnt_q] && !w_done_q;
        s_awready[wr_gnt_q] = m_awready && !aw_done_q;
        s_wready[wr_gnt_q]  = m_wready && !w_done_q;
        if (m_awvalid && m_awready) aw_done_d = 1'b1;
        if (m_wvalid && m_wready)   w_done_d  = 1'b1;
        if (aw_done_d && w_done_d)  wr_state_d = W_RESP;
      end
      W_RESP: begin
        s_bvalid[wr_gnt_q] = m_bvalid;
        m_bready           = s_bready[wr_gnt_q];
        if (m_bvalid && m_bready) begin
          wr_ptr_d   = ptr_after(wr_gnt_q);
          wr_state_d = W_IDLE;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rd_gnt_d   = rd_gnt_q;
    rd_ptr_d   = rd_ptr_q;
    s_arready  = '0;
    s_rvalid   = '0;
    m_arvalid  = 1'b0;
    m_rready   = 1'b0;
    case (rd_state_q)
      R_IDLE: begin
        if (rd_arb_valid) begin
          rd_gnt_d   = rd_arb_idx;
          rd_state_d = R_ADDR;
        end
      end
      R_ADDR: begin
        m_arvalid           = s_arvalid[rd_gnt_q];
        s_arready[rd_gnt_q] = m_arready;
        if (m_arvalid && m_arready) rd_state_d = R_DATA;
      end
      R_DATA: begin
        s_rvalid[rd_gnt_q] = m_rvalid;
        m_rready           = s_rready[rd_gnt_q];
        if (m_rvalid && m_rready) begin
          rd_ptr_d   = ptr_after(rd_gnt_q);
          rd_state_d = R_IDLE;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wr_state_q <= W_IDLE;
      rd_state_q <= R_IDLE;
      wr_gnt_q   <= '0;
      rd_gnt_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      wr_gnt_q   <= wr_gnt_d;
      rd_gnt_q   <= rd_gnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
    end
  end

endmodule

// File: tb/tb_axi_lite_rr_arbiter.sv
// Bench for axi_lite_rr_arbiter: directed scenarios plus randomized traffic
// checked against a round-robin reference model and a write scoreboard.
module tb_axi_lite_rr_arbiter;
  import axi_lite_arb_pkg::*;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int IW = 2;

  logic ACLK = 1'b0;
  logic ARESET;
  logic [N*AW-1:0] s_awaddr, s_araddr;
  logic [N-1:0]    s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic [N-1:0]    s_arvalid, s_arready, s_rvalid, s_rready;
  logic [N*DW-1:0] s_wdata, s_rdata;
  logic [N*SW-1:0] s_wstrb;
  logic [N*2-1:0]  s_bresp, s_rresp;
  logic [AW-1:0]   m_awaddr, m_araddr;
  logic            m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic            m_arvalid, m_arready, m_rvalid, m_rready;
  logic [DW-1:0]   m_wdata, m_rdata;
  logic [SW-1:0]   m_wstrb;
  logic [1:0]      m_bresp, m_rresp;
  logic [IW-1:0]   wr_grant_idx, rd_grant_idx;
  logic            wr_busy, rd_busy;

  always #5 ACLK = ~ACLK;

  axi_lite_rr_arbiter #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .wr_grant_idx(wr_grant_idx), .rd_grant_idx(rd_grant_idx),
    .wr_busy(wr_busy), .rd_busy(rd_busy)
  );

  int tests = 0;
  int fails = 0;
  int model_wr_ptr = 0;
  int model_rd_ptr = 0;
  logic [AW-1:0] wr_addr[N];
  logic [DW-1:0] wr_data[N];
  logic [SW-1:0] wr_strb[N];
  logic [AW-1:0] rd_addr[N];
  int wr_wait[N];
  int rd_wait[N];
  logic [AW+DW+SW-1:0] exp_q[$];

  // Reference rule: first requester at or after the pointer, wrapping.
  function automatic int pick(input logic [N-1:0] mask, input int ptr);
    for (int k = 0; k < N; k++)
      if (mask[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int i, input logic en);
    logic [N-1:0] v;
    v = '0;
    v[i] = en;
    return v;
  endfunction

  task automatic post_write(input int m, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [SW-1:0] s);
    wr_addr[m] = a; wr_data[m] = d; wr_strb[m] = s;
    s_awaddr[m*AW +: AW] = a;
    s_wdata[m*DW +: DW]  = d;
    s_wstrb[m*SW +: SW]  = s;
    s_awvalid[m] = 1'b1;
    s_wvalid[m]  = 1'b1;
    wr_wait[m]   = 0;
  endtask

  task automatic post_read(input int m, input logic [AW-1:0] a);
    rd_addr[m] = a;
    s_araddr[m*AW +: AW] = a;
    s_arvalid[m] = 1'b1;
    rd_wait[m]   = 0;
  endtask

  task automatic write_round(input logic [1:0] bresp, input int max_stall);
    int w, bstall;
    logic aw_seen, w_seen, hs_aw, hs_w;
    logic [AW+DW+SW-1:0] exp;
    #1;
    w = pick(s_awvalid, model_wr_ptr);
    if (w < 0) begin
      tests++; fails++;
      $display("FAIL wr_pick: no pending write requester, required at least one");
      return;
    end
    exp_q.push_back({wr_addr[w], wr_data[w], wr_strb[w]});
    tests++;
    if (m_awvalid !== 1'b0 || s_awready !== '0 || wr_busy !== 1'b0) begin
      fails++;
      $display("FAIL wr_idle: m_awvalid=%b s_awready=%b busy=%b required 0/0/0",
               m_awvalid, s_awready, wr_busy);
    end
    @(posedge ACLK); #1;
    tests++;
    if (wr_grant_idx !== IW'(w) || wr_busy !== 1'b1) begin
      fails++;
      $display("FAIL wr_grant: idx=%0d busy=%b required idx=%0d busy=1", wr_grant_idx, wr_busy, w);
    end
    tests++;
    if (wr_wait[w] > N - 1) begin
      fails++;
      $display("FAIL wr_starve: master %0d waited %0d grants, required <= %0d", w, wr_wait[w], N - 1);
    end
    for (int i = 0; i < N; i++) if (i != w && s_awvalid[i]) wr_wait[i]++;
    exp = exp_q.pop_front();
    aw_seen = 1'b0;
    w_seen  = 1'b0;
    for (int cyc = 0; cyc < 40 && !(aw_seen && w_seen); cyc++) begin
      m_awready = ($urandom_range(0, max_stall) == 0);
      m_wready  = ($urandom_range(0, max_stall) == 0);
      #1;
      tests++;
      if (m_awvalid !== !aw_seen || m_wvalid !== (s_wvalid[w] && !w_seen)) begin
        fails++;
        $display("FAIL wr_m_valid: awvalid=%b wvalid=%b required %b/%b", m_awvalid, m_wvalid,
                 !aw_seen, s_wvalid[w] && !w_seen);
      end
      tests++;
      if (s_awready !== onehot(w, m_awready && !aw_seen) ||
          s_wready !== onehot(w, m_wready && !w_seen)) begin
        fails++;
        $display("FAIL wr_s_ready: awready=%b wready=%b required %b/%b", s_awready, s_wready,
                 onehot(w, m_awready && !aw_seen), onehot(w, m_wready && !w_seen));
      end
      hs_aw = !aw_seen && m_awready;
      hs_w  = !w_seen && s_wvalid[w] && m_wready;
      if (hs_aw) begin
        tests++;
        if (m_awaddr !== exp[AW+DW+SW-1 -: AW]) begin
          fails++;
          $display("FAIL wr_addr: got %h required %h", m_awaddr, exp[AW+DW+SW-1 -: AW]);
        end
      end
      if (hs_w) begin
        tests++;
        if (m_wdata !== exp[DW+SW-1 -: DW] || m_wstrb !== exp[SW-1:0]) begin
          fails++;
          $display("FAIL wr_data: got %h/%h required %h/%h", m_wdata, m_wstrb,
                   exp[DW+SW-1 -: DW], exp[SW-1:0]);
        end
      end
      @(posedge ACLK); #1;
      if (hs_aw) begin s_awvalid[w] = 1'b0; aw_seen = 1'b1; end
      if (hs_w)  begin s_wvalid[w]  = 1'b0; w_seen  = 1'b1; end
    end
    m_awready = 1'b0;
    m_wready  = 1'b0;
    if (!(aw_seen && w_seen)) begin
      tests++; fails++;
      $display("FAIL wr_timeout: aw_seen=%b w_seen=%b required 1/1", aw_seen, w_seen);
      s_awvalid[w] = 1'b0; s_wvalid[w] = 1'b0;
      return;
    end
    bstall = $urandom_range(0, max_stall);
    m_bvalid = 1'b1;
    m_bresp  = bresp;
    repeat (bstall) begin
      #1;
      tests++;
      if (s_bvalid !== onehot(w, 1'b1) || m_bready !== 1'b0 || s_bresp !== {N{bresp}} ||
          m_awvalid !== 1'b0 || m_wvalid !== 1'b0) begin
        fails++;
        $display("FAIL wr_b_stall: bvalid=%b bready=%b bresp=%h awv=%b wv=%b required %b/0/%h/0/0",
                 s_bvalid, m_bready, s_bresp, m_awvalid, m_wvalid, onehot(w, 1'b1), {N{bresp}});
      end
      @(posedge ACLK); #1;
    end
    s_bready[w] = 1'b1;
    #1;
    tests++;
    if (s_bvalid !== onehot(w, 1'b1) || m_bready !== 1'b1 || s_bresp !== {N{bresp}}) begin
      fails++;
      $display("FAIL wr_b: bvalid=%b bready=%b bresp=%h required %b/1/%h",
               s_bvalid, m_bready, s_bresp, onehot(w, 1'b1), {N{bresp}});
    end
    @(posedge ACLK); #1;
    m_bvalid = 1'b0;
    s_bready[w] = 1'b0;
    model_wr_ptr = (w + 1) % N;
    #1;
    tests++;
    if (wr_busy !== 1'b0 || s_bvalid !== '0) begin
      fails++;
      $display("FAIL wr_done: busy=%b bvalid=%b required 0/0", wr_busy, s_bvalid);
    end
  endtask

  task automatic read_round(input logic [DW-1:0] rdata, input logic [1:0] rresp,
                            input int max_stall, input int rstall);
    int r;
    logic seen, hs;
    #1;
    r = pick(s_arvalid, model_rd_ptr);
    if (r < 0) begin
      tests++; fails++;
      $display("FAIL rd_pick: no pending read requester, required at least one");
      return;
    end
    tests++;
    if (m_arvalid !== 1'b0 || s_arready !== '0 || rd_busy !== 1'b0) begin
      fails++;
      $display("FAIL rd_idle: m_arvalid=%b s_arready=%b busy=%b required 0/0/0",
               m_arvalid, s_arready, rd_busy);
    end
    @(posedge ACLK); #1;
    tests++;
    if (rd_grant_idx !== IW'(r) || rd_busy !== 1'b1) begin
      fails++;
      $display("FAIL rd_grant: idx=%0d busy=%b required idx=%0d busy=1", rd_grant_idx, rd_busy, r);
    end
    tests++;
    if (rd_wait[r] > N - 1) begin
      fails++;
      $display("FAIL rd_starve: master %0d waited %0d grants, required <= %0d", r, rd_wait[r], N - 1);
    end
    for (int i = 0; i < N; i++) if (i != r && s_arvalid[i]) rd_wait[i]++;
    seen = 1'b0;
    for (int cyc = 0; cyc < 40 && !seen; cyc++) begin
      m_arready = ($urandom_range(0, max_stall) == 0);
      #1;
      tests++;
      if (m_arvalid !== 1'b1 || s_arready !== onehot(r, m_arready)) begin
        fails++;
        $display("FAIL rd_ar: arvalid=%b arready=%b required 1/%b", m_arvalid, s_arready,
                 onehot(r, m_arready));
      end
      hs = m_arready;
      if (hs) begin
        tests++;
        if (m_araddr !== rd_addr[r]) begin
          fails++;
          $display("FAIL rd_addr: got %h required %h", m_araddr, rd_addr[r]);
        end
      end
      @(posedge ACLK); #1;
      if (hs) begin s_arvalid[r] = 1'b0; seen = 1'b1; end
    end
    m_arready = 1'b0;
    if (!seen) begin
      tests++; fails++;
      $display("FAIL rd_timeout: AR handshake not seen, required within 40 cycles");
      s_arvalid[r] = 1'b0;
      return;
    end
    m_rvalid = 1'b1;
    m_rdata  = rdata;
    m_rresp  = rresp;
    repeat (rstall) begin
      #1;
      tests++;
      if (s_rvalid !== onehot(r, 1'b1) || m_rready !== 1'b0 || s_rdata !== {N{rdata}} ||
          s_rresp !== {N{rresp}} || m_arvalid !== 1'b0) begin
        fails++;
        $display("FAIL rd_r_stall: rvalid=%b rready=%b rdata=%h arv=%b required %b/0/%h/0",
                 s_rvalid, m_rready, s_rdata, m_arvalid, onehot(r, 1'b1), {N{rdata}});
      end
      @(posedge ACLK); #1;
    end
    s_rready[r] = 1'b1;
    #1;
    tests++;
    if (s_rvalid !== onehot(r, 1'b1) || m_rready !== 1'b1 || s_rdata[r*DW +: DW] !== rdata ||
        s_rresp[r*2 +: 2] !== rresp) begin
      fails++;
      $display("FAIL rd_r: rvalid=%b rready=%b rdata=%h rresp=%b required %b/1/%h/%b",
               s_rvalid, m_rready, s_rdata[r*DW +: DW], s_rresp[r*2 +: 2], onehot(r, 1'b1),
               rdata, rresp);
    end
    @(posedge ACLK); #1;
    m_rvalid = 1'b0;
    s_rready[r] = 1'b0;
    model_rd_ptr = (r + 1) % N;
    #1;
    tests++;
    if (rd_busy !== 1'b0 || s_rvalid !== '0) begin
      fails++;
      $display("FAIL rd_done: busy=%b rvalid=%b required 0/0", rd_busy, s_rvalid);
    end
  endtask

  task automatic clear_inputs();
    s_awaddr = '0; s_awvalid = '0; s_wdata = '0; s_wstrb = '0; s_wvalid = '0; s_bready = '0;
    s_araddr = '0; s_arvalid = '0; s_rready = '0;
    m_awready = 1'b0; m_wready = 1'b0; m_bresp = 2'b00; m_bvalid = 1'b0;
    m_arready = 1'b0; m_rdata = '0; m_rresp = 2'b00; m_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    ARESET = 1'b1;
    clear_inputs();
    s_awvalid = '1; s_wvalid = '1; s_arvalid = '1; s_bready = '1; s_rready = '1;
    m_awready = 1'b1; m_wready = 1'b1; m_arready = 1'b1; m_bvalid = 1'b1; m_rvalid = 1'b1;
    repeat (3) @(posedge ACLK);
    #1;
    tests++;
    if (wr_busy !== 1'b0 || rd_busy !== 1'b0) begin
      fails++; $display("FAIL rst_busy: wr=%b rd=%b required 0/0", wr_busy, rd_busy);
    end
    tests++;
    if (wr_grant_idx !== '0 || rd_grant_idx !== '0) begin
      fails++; $display("FAIL rst_grant: wr=%0d rd=%0d required 0/0", wr_grant_idx, rd_grant_idx);
    end
    tests++;
    if ({s_awready, s_wready, s_bvalid, s_arready, s_rvalid} !== '0) begin
      fails++;
      $display("FAIL rst_s_out: awr=%b wr=%b bv=%b arr=%b rv=%b required all 0",
               s_awready, s_wready, s_bvalid, s_arready, s_rvalid);
    end
    tests++;
    if ({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready} !== '0) begin
      fails++;
      $display("FAIL rst_m_out: %b required 00000", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready});
    end
    clear_inputs();
    ARESET = 1'b0;
    @(posedge ACLK); #1;
    tests++;
    if (wr_busy !== 1'b0 || rd_busy !== 1'b0) begin
      fails++; $display("FAIL rst_idle: wr=%b rd=%b required 0/0", wr_busy, rd_busy);
    end
  endtask

  task automatic test_single_write();
    post_write(0, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
    write_round(RESP_OKAY, 0);
  endtask

  task automatic test_contention();
    post_write(1, 32'h0000_0104, 32'h1111_0001, 4'h3);
    post_write(2, 32'h0000_0208, 32'h2222_0002, 4'hC);
    post_write(3, 32'h0000_030C, 32'h3333_0003, 4'hF);
    repeat (3) write_round(RESP_OKAY, 2);
  endtask

  task automatic test_w_before_aw();
    post_write(2, 32'h0000_0040, 32'hA5A5_5A5A, 4'h6);
    s_awvalid[2] = 1'b0;
    repeat (3) begin
      @(posedge ACLK); #1;
      tests++;
      if (wr_busy !== 1'b0 || m_wvalid !== 1'b0 || s_wready !== '0) begin
        fails++;
        $display("FAIL w_early: busy=%b m_wvalid=%b s_wready=%b required 0/0/0",
                 wr_busy, m_wvalid, s_wready);
      end
    end
    s_awvalid[2] = 1'b1;
    write_round(RESP_SLVERR, 1);
  endtask

  task automatic test_concurrent();
    post_read(0, 32'h0000_0020);
    post_write(3, 32'h0000_0024, $urandom, 4'hF);
    fork
      write_round(RESP_OKAY, 2);
      read_round(32'h0000_1234, RESP_OKAY, 2, 1);
    join
  endtask

  task automatic test_backpressure();
    post_read(1, 32'h0000_0044);
    read_round(32'hCAFE_0001, RESP_EXOKAY, 0, 5);
  endtask

  task automatic test_random();
    fork
      begin
        for (int rnd = 0; rnd < 25; rnd++) begin
          for (int m = 0; m < N; m++)
            if (!s_awvalid[m] && $urandom_range(0, 1) == 1)
              post_write(m, $urandom, $urandom, 4'($urandom_range(1, 15)));
          if (s_awvalid == '0)
            post_write($urandom_range(0, N - 1), $urandom, $urandom, 4'hF);
          write_round(2'($urandom_range(0, 3)), 2);
        end
        while (s_awvalid != '0) write_round(RESP_OKAY, 1);
      end
      begin
        for (int rnd = 0; rnd < 25; rnd++) begin
          for (int m = 0; m < N; m++)
            if (!s_arvalid[m] && $urandom_range(0, 1) == 1) post_read(m, $urandom);
          if (s_arvalid == '0) post_read($urandom_range(0, N - 1), $urandom);
          read_round($urandom, 2'($urandom_range(0, 3)), 2, $urandom_range(0, 2));
        end
        while (s_arvalid != '0) read_round($urandom, RESP_OKAY, 1, 0);
      end
    join
  endtask

  task automatic test_reset_mid_xfer();
    post_read(2, 32'h0000_0300);
    read_round(32'h0BAD_F00D, RESP_OKAY, 0, 0);
    post_write(2, 32'h0000_0310, 32'h0000_2222, 4'hF);
    write_round(RESP_OKAY, 0);
    post_write(1, 32'h0000_0080, 32'h5555_AAAA, 4'hF);
    @(posedge ACLK); #1;
    m_awready = 1'b1;
    m_wready  = 1'b0;
    @(posedge ACLK); #1;
    s_awvalid[1] = 1'b0;
    m_awready = 1'b0;
    tests++;
    if (wr_busy !== 1'b1 || m_wvalid !== 1'b1) begin
      fails++;
      $display("FAIL mid_xfer: busy=%b m_wvalid=%b required 1/1", wr_busy, m_wvalid);
    end
    ARESET = 1'b1;
    m_wready = 1'b1;
    m_bvalid = 1'b1;
    @(posedge ACLK); #1;
    tests++;
    if (wr_busy !== 1'b0 || rd_busy !== 1'b0 || wr_grant_idx !== '0 || rd_grant_idx !== '0) begin
      fails++;
      $display("FAIL mid_rst_state: busy=%b/%b idx=%0d/%0d required 0/0 0/0",
               wr_busy, rd_busy, wr_grant_idx, rd_grant_idx);
    end
    tests++;
    if ({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready} !== '0 ||
        {s_awready, s_wready, s_bvalid, s_arready, s_rvalid} !== '0) begin
      fails++;
      $display("FAIL mid_rst_out: m=%b s_wready=%b s_bvalid=%b required all 0",
               {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}, s_wready, s_bvalid);
    end
    clear_inputs();
    ARESET = 1'b0;
    model_wr_ptr = 0;
    model_rd_ptr = 0;
    for (int m = 0; m < N; m++) begin
      post_write(m, 32'h0000_0400 + 32'(m * 4), $urandom, 4'hF);
      post_read(m, 32'h0000_0500 + 32'(m * 4));
    end
    fork
      write_round(RESP_OKAY, 0);
      read_round(32'h7777_0000, RESP_OKAY, 0, 0);
    join
  endtask

  initial begin
    ARESET = 1'b1;
    clear_inputs();
    for (int m = 0; m < N; m++) begin
      wr_addr[m] = '0; wr_data[m] = '0; wr_strb[m] = '0; rd_addr[m] = '0;
      wr_wait[m] = 0; rd_wait[m] = 0;
    end
    test_reset();
    test_single_write();
    test_contention();
    test_w_before_aw();
    test_concurrent();
    test_backpressure();
    test_random();
    test_reset_mid_xfer();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1);
  end

endmodule

// File: doc/axi_lite_rr_arbiter.md
Name: axi_lite_rr_arbiter

Overview:
Parametrised N-to-1 AXI4-Lite arbiter that places NUM_MASTERS master ports onto a single downstream slave port. Write and read paths arbitrate independently, each with its own round-robin pointer. A grant is held for the whole transaction: AW+W+B on the write path, AR+R on the read path. The block sits between CPU/DMA masters and the shared register-bus slave.

Parameters:
NUM_MASTERS, 4, number of upstream masters (2..16)
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data width (multiple of 8)
IDX_W, $clog2(NUM_MASTERS), grant index width (derived, not overridable)

Ports:
ACLK  in  1  clock
ARESET  in  1  synchronous active-high reset
s_awaddr  in  NUM_MASTERS*ADDR_WIDTH  packed per-master AW address, master i at slice i
s_awvalid / s_awready  in/out  NUM_MASTERS  per-master AW handshake
s_wdata  in  NUM_MASTERS*DATA_WIDTH  per-master write data
s_wstrb  in  NUM_MASTERS*DATA_WIDTH/8  per-master strobes
s_wvalid / s_wready  in/out  NUM_MASTERS  per-master W handshake
s_bresp  out  NUM_MASTERS*2  per-master write response (broadcast value)
s_bvalid / s_bready  out/in  NUM_MASTERS  per-master B handshake
s_araddr  in  NUM_MASTERS*ADDR_WIDTH  per-master read address
s_arvalid / s_arready  in/out  NUM_MASTERS  per-master AR handshake
s_rdata / s_rresp  out  NUM_MASTERS*DATA_WIDTH / NUM_MASTERS*2  read data/resp (broadcast value)
s_rvalid / s_rready  out/in  NUM_MASTERS  per-master R handshake
m_awaddr, m_awvalid / m_awready  out, out/in  ADDR_WIDTH, 1/1  downstream AW
m_wdata, m_wstrb, m_wvalid / m_wready  out  DATA_WIDTH, DATA_WIDTH/8, 1/1(in)  downstream W
m_bresp, m_bvalid / m_bready  in, in/out  2, 1/1  downstream B
m_araddr, m_arvalid / m_arready  out, out/in  ADDR_WIDTH, 1/1  downstream AR
m_rdata, m_rresp, m_rvalid / m_rready  in, in/out  DATA_WIDTH, 2, 1/1  downstream R
wr_grant_idx / rd_grant_idx  out  IDX_W  current grant index (debug)
wr_busy / rd_busy  out  1  path not IDLE

Behaviour:
- Write FSM states: W_IDLE, W_XFER, W_RESP.
- W_IDLE: if any s_awvalid, pick the first requester at or after wr_ptr (wrapping modulo NUM_MASTERS). Register the grant and go to W_XFER next cycle. Grant latency is 1 cycle; no combinational valid->ready path in IDLE.
- W_XFER: route the granted master's AW/W to m_*; its s_awready = m_awready && !aw_done and s_wready = m_wready && !w_done. aw_done/w_done set on their handshakes and may complete in either order or the same cycle. When both are done, go to W_RESP.
- W_RESP: s_bvalid[g] = m_bvalid, m_bready = s_bready[g]. On handshake: wr_ptr <= g+1 (wrapping NUM_MASTERS-1 -> 0), then W_IDLE.
- Read FSM states: R_IDLE, R_ADDR, R_DATA. Same arbitration over s_arvalid using rd_ptr. On AR handshake go to R_DATA; on R handshake set rd_ptr <= g+1 and go to R_IDLE.
- Non-granted masters: all ready and valid outputs are 0. m_* valids are 0 outside W_XFER/R_ADDR (AW/W after done) and outside RESP/DATA (B/R readies).
- Data/resp outputs are broadcast to all slices; only valid is qualified per master.
- Simultaneous requests: the round-robin pointer decides. A master that keeps requesting cannot starve others; worst-case wait is NUM_MASTERS-1 transactions.
- A read and a write may proceed concurrently, including from the same master.
- Reset: FSMs go to IDLE, pointers to 0, done flags to 0, all ready/valid outputs to 0, grant_idx to 0, busy to 0. Reset mid-transaction abandons it; no response is delivered.
- Valid is held by masters per AXI; the block does not drop a grant while a handshake is pending.

Decomposition:
- Package axi_lite_arb_pkg: wr_state_t and rd_state_t enums, and RESP_OKAY/EXOKAY/SLVERR/DECERR constants.
- Sub-module rr_arbiter (NUM_REQ parameter; inputs req vector and ptr; outputs gnt_idx and gnt_valid), combinational, instantiated once per path.

Test Plan:
- Single write: M0 writes 0x10=0xDEADBEEF, strb 0xF, slave BRESP=OKAY. Expect m_aw/w observed 1 cycle after request, B to M0 only, wr_ptr=1.
- Contention, NUM_MASTERS=4: M1, M2 and M3 all issue AW at cycle 0 with wr_ptr=0. Expect grant order M1, M2, M3; no overlap on m_*.
- W before AW: M2 asserts wvalid 3 cycles before awvalid. Expect single downstream transaction with data intact and BRESP=SLVERR routed to M2.
- Concurrent paths: M0 reads 0x20 (RDATA=0x1234) while M3 writes 0x24. Expect both complete independently; rd_grant_idx=0, wr_grant_idx=3.
- Backpressure: m_rready stalled for 5 cycles by s_rready[1]=0. Expect m_rvalid held and RDATA stable.
- Reset in W_XFER: ARESET after AW accepted, before W. Expect all valids/readies 0 next cycle, busy=0, pointers=0.
